godai_data_mem_responder: RTL and testbench
===========================================

// Module: godai_data_mem_responder
// PURPOSE
//  Memory-side end of the core data interface (req/gnt/rvalid, byte enables, err): single-ported
//  word SRAM model answering the core's data port in simulation and FPGA builds.
//  Programmable grant and response latency exercise core stalls and trace timing; one request
//  outstanding at a time; out-of-range accesses answered with an error response.
// PARAMETERS
//  ADDR_WIDTH      32     byte address width
//  DATA_WIDTH      32     data width (fixed 32; 4 byte enables)
//  MEM_WORDS       1024   number of 32-bit words in the array
//  BASE_ADDR       32'h0  byte address of word 0 (word aligned)
//  GNT_LATENCY     1      cycles from first req to gnt, 0..15 (0 = same-cycle gnt)
//  RVALID_LATENCY  1      cycles from accepting edge to rvalid, 1..15
// PORTS
//  clk            in   1    clock; all logic on rising edge
//  rst            in   1    reset, synchronous, active-high
//  data_req_i     in   1    request; held with addr/we/be/wdata stable until gnt
//  data_gnt_o     out  1    grant; transfer accepted in cycle with req_i && gnt_o
//  data_rvalid_o  out  1    response valid, one-cycle pulse per accepted transfer
//  data_we_i      in   1    1 = write, 0 = read
//  data_be_i      in   4    byte enables; bit n enables byte n (bits 8n+7:8n)
//  data_addr_i    in   ADDR_WIDTH  byte address; bits 1:0 ignored
//  data_wdata_i   in   32   write data
//  data_rdata_o   out  32   read data, valid with rvalid_o
//  data_err_o     out  1    error, valid with rvalid_o
// BEHAVIOUR
//  Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, FSM=IDLE, counters 0; array NOT cleared.
//  Decode: idx=(addr-BASE_ADDR)>>2; in_range = addr>=BASE_ADDR && addr<BASE_ADDR+4*MEM_WORDS.
//  FSM states IDLE, WAIT, RESP:
//   IDLE: req && GNT_LATENCY==0 -> gnt_o=1 (combinational), accept, ->RESP.
//         req && GNT_LATENCY>0  -> load gcnt=GNT_LATENCY-1, ->WAIT.
//   WAIT: gnt_o=0 while gcnt!=0 (decrement); gcnt==0 -> gnt_o=1, accept, ->RESP.
//         req dropped before gnt (protocol violation) -> ->IDLE, no access, no rvalid.
//   RESP: rcnt loaded RVALID_LATENCY-1 at accept; decrement; registered rvalid_o=1 in
//         cycle RVALID_LATENCY after the accepting cycle. That cycle acts as IDLE for a
//         new req (back-to-back; with GNT_LATENCY=0, gnt_o and rvalid_o high together).
//  gnt_o only ever asserted when data_req_i=1; never asserted in RESP before rvalid cycle.
//  Accept edge, write, in_range: array[idx] byte n <= wdata byte n where be[n]=1; be=0 ->
//   no change, response still issued. Write response: rdata_o=0, err_o=0.
//  Accept edge, read, in_range: array[idx] captured (all 4 bytes regardless of be); shown
//   on rdata_o with rvalid_o. Write-then-read same word returns new data (single outstanding).
//  Not in_range: no array access; response rdata_o=0, err_o=1.
//  rdata_o/err_o hold last response value when rvalid_o=0; rvalid_o low except pulse cycle.
//  Reset mid-transaction: pending transfer dropped, no rvalid; completed writes retained.
// TESTING
//  GNT_LATENCY=0, RVALID=1: write 0xDEADBEEF be=4'hF @0x10, read @0x10 -> gnt same cycle
//   as req, rvalid next cycle, rdata=0xDEADBEEF, err=0.
//  Partial write: word=0x11223344, write 0x0000AA00 be=4'b0010 -> read returns 0x1122AA44.
//  GNT_LATENCY=3, RVALID=2: req at cycle 0 -> gnt at cycle 3, rvalid at cycle 5; req held
//   high throughout, no earlier gnt/rvalid.
//  Out of range: MEM_WORDS=1024, read @0x1000 -> rvalid, err=1, rdata=0; write there ->
//   err=1, array unchanged (read @0x0..0xFFC compares against scoreboard).
//  Back-to-back: GNT_LATENCY=0, 8 consecutive reads with req always high -> gnt and rvalid
//   coincide each cycle after first, 8 rvalid pulses, data in issue order.
//  Reset in RESP (RVALID=4) at cycle 2 after accept -> no rvalid, all outputs 0 next cycle,
//   prior written word still readable after reset.

Source files
------------

// File: rtl/godai_data_mem_responder.sv
// Memory-side responder for the core data port: word SRAM with
// programmable grant/response latency, one transfer outstanding.
module godai_data_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int GNT_LATENCY = 1,
  parameter int RVALID_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int IW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(4 * MEM_WORDS);
  localparam logic [3:0] GL_M1 =
    (GNT_LATENCY > 0) ? 4'(GNT_LATENCY - 1) : 4'd0;
  localparam logic [3:0] RL_M1 =
    4'(RVALID_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [3:0] rcnt_q, rcnt_d;

  logic rvalid_q;
  logic err_q;
  logic hold_err;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] hold_data;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH:0] diff;
  logic in_range;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] acc_data;
  logic acc_err;

  logic rv_cycle;
  logic idle_like;
  logic wait_st;
  logic resp_busy;
  logic grant;
  logic accept;
  logic fire_now;
  logic fire_late;
  logic fire;

  // Borrow out of the subtraction flags addr below BASE_ADDR.
  assign diff = {1'b0, data_addr_i}
              - {1'b0, BASE_ADDR};
  assign in_range = !diff[ADDR_WIDTH]
    && (diff[ADDR_WIDTH-1:0] < SPAN);
  assign idx = diff[IW+1:2];

  assign acc_data = (!data_we_i && in_range)
    ? mem[idx] : '0;
  assign acc_err = !in_range;

  assign rv_cycle = (state_q == S_RESP)
    && (rcnt_q == 4'd0);
  assign idle_like = (state_q == S_IDLE)
    || rv_cycle;
  assign wait_st = (state_q == S_WAIT);
  assign resp_busy = (state_q == S_RESP)
    && (rcnt_q != 4'd0);

  always_comb begin
    state_d = state_q;
    gcnt_d = gcnt_q;
    rcnt_d = rcnt_q;
    grant = 1'b0;
    unique case (1'b1)
      idle_like: begin
        state_d = S_IDLE;
        if (data_req_i) begin
          if (GNT_LATENCY == 0) begin
            grant = 1'b1;
          end else begin
            gcnt_d = GL_M1;
            state_d = S_WAIT;
          end
        end
      end
      wait_st: begin
        if (!data_req_i) begin
          state_d = S_IDLE;
        end else if (gcnt_q == 4'd0) begin
          grant = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      resp_busy: begin
        rcnt_d = rcnt_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (grant && !rst) begin
      state_d = S_RESP;
      rcnt_d = RL_M1;
    end
  end

  assign accept = grant && !rst;
  assign data_gnt_o = accept;

  // Latency 1 responds straight from the accept edge.
  assign fire_now = accept
    && (RVALID_LATENCY == 1);
  assign fire_late = resp_busy
    && (rcnt_q == 4'd1);
  assign fire = fire_now || fire_late;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gcnt_q <= '0;
      rcnt_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      hold_data <= '0;
      hold_err <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q <= gcnt_d;
      rcnt_q <= rcnt_d;
      rvalid_q <= fire;
      if (accept) begin
        hold_data <= acc_data;
        hold_err <= acc_err;
      end
      if (fire_now) begin
        rdata_q <= acc_data;
        err_q <= acc_err;
      end else if (fire_late) begin
        rdata_q <= hold_data;
        err_q <= hold_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && data_we_i && in_range) begin
      for (int b = 0; b < BW; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8]
            <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o = rdata_q;
  assign data_err_o = err_q;

endmodule

// File: tb/tb_godai_data_mem_responder.sv
// Directed bench for the data memory responder in three
// latency configurations.
module tb_godai_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];

  int exp_gl [3] = '{0, 3, 0};
  int exp_rl [3] = '{1, 2, 4};

  int n_tests = 0;
  int n_fail = 0;

  godai_data_mem_responder #(
    .GNT_LATENCY(0), .RVALID_LATENCY(1)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]),
    .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0])
  );

  godai_data_mem_responder #(
    .GNT_LATENCY(3), .RVALID_LATENCY(2)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]),
    .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1])
  );

  godai_data_mem_responder #(
    .GNT_LATENCY(0), .RVALID_LATENCY(4)
  ) u2 (
    .clk(clk), .rst(rst[2]),
    .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rvalid[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_addr_i(addr[2]),
    .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]),
    .data_err_o(err[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic xfer(input int i,
                      input logic w,
                      input logic [3:0] b,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output logic e,
                      output int gc,
                      output int rc);
    bit ok;
    rd = '0;
    e = 1'b0;
    rc = 0;
    req[i] = 1'b1;
    we[i] = w;
    be[i] = b;
    addr[i] = a;
    wdata[i] = d;
    gc = 0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (gnt[i]) ok = 1'b1;
      else begin
        gc++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      check("gnt_timeout", 32'(ok), 32'd1);
      req[i] = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    we[i] = 1'b0;
    rc = 1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (rvalid[i]) begin
        ok = 1'b1;
        rd = rdata[i];
        e = err[i];
      end else begin
        rc++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      check("rv_timeout", 32'(ok), 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rv_pulse", 32'(rvalid[i]), 32'd0);
    check("rd_hold", rdata[i], rd);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int i,
                     input logic w,
                     input logic [3:0] b,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] exp_rd,
                     input logic exp_err,
                     input string tag);
    logic [31:0] rd;
    logic e;
    int gc, rc;
    xfer(i, w, b, a, d, rd, e, gc, rc);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_gnt_lat"}, gc, exp_gl[i]);
    check({tag, "_rv_lat"}, rc, exp_rl[i]);
  endtask

  logic [31:0] v [8];
  int pulses;
  int hits;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      req[i] = 1'b0;
      we[i] = 1'b0;
      be[i] = 4'h0;
      addr[i] = '0;
      wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_gnt", 32'(gnt[i]), 32'd0);
      check("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'd0);
      check("rst_err", 32'(err[i]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Basic write/read, zero grant latency
    txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF,
        32'h0, 0, "wr10");
    txn(0, 0, 4'hF, 32'h10, 32'h0,
        32'hDEADBEEF, 0, "rd10");

    // Byte enables
    txn(0, 1, 4'hF, 32'h20, 32'h11223344,
        32'h0, 0, "wr20");
    txn(0, 1, 4'b0010, 32'h20, 32'h0000AA00,
        32'h0, 0, "wr20_be2");
    txn(0, 0, 4'h0, 32'h20, 32'h0,
        32'h1122AA44, 0, "rd20_a");
    txn(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF,
        32'h0, 0, "wr20_be0");
    txn(0, 1, 4'b1001, 32'h20, 32'hCC0000DD,
        32'h0, 0, "wr20_be9");
    txn(0, 0, 4'hF, 32'h20, 32'h0,
        32'hCC22AADD, 0, "rd20_b");

    // Range boundaries
    txn(0, 1, 4'hF, 32'h0, 32'h0BADF00D,
        32'h0, 0, "wr0");
    txn(0, 1, 4'hF, 32'hFFC, 32'h5A5AA5A5,
        32'h0, 0, "wrffc");
    txn(0, 0, 4'hF, 32'h1000, 32'h0,
        32'h0, 1, "rd_oor");
    txn(0, 1, 4'hF, 32'h1000, 32'h77777777,
        32'h0, 1, "wr_oor");
    txn(0, 0, 4'hF, 32'h0, 32'h0,
        32'h0BADF00D, 0, "rd0_after_oor");
    txn(0, 0, 4'hF, 32'hFFC, 32'h0,
        32'h5A5AA5A5, 0, "rdffc");

    // Back-to-back reads with req held high
    for (int k = 0; k < 8; k++) begin
      v[k] = 32'hA0000000 + 32'(k) * 32'h01010101;
      txn(0, 1, 4'hF, 32'h100 + 32'(4 * k), v[k],
          32'h0, 0, "b2b_fill");
    end
    pulses = 0;
    req[0] = 1'b1;
    we[0] = 1'b0;
    be[0] = 4'hF;
    addr[0] = 32'h100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_gnt", 32'(gnt[0]), 32'd1);
      if (rvalid[0]) pulses++;
      if (k > 0) begin
        check("b2b_rvalid", 32'(rvalid[0]), 32'd1);
        check("b2b_rdata", rdata[0], v[k-1]);
      end
      @(posedge clk);
      #1;
      if (k < 7) addr[0] = 32'h100 + 32'(4 * (k + 1));
      else req[0] = 1'b0;
    end
    @(negedge clk);
    if (rvalid[0]) pulses++;
    check("b2b_last", rdata[0], v[7]);
    check("b2b_pulses", pulses, 32'd8);
    @(posedge clk);
    #1;

    // Grant latency 3, response latency 2
    txn(1, 1, 4'hF, 32'h40, 32'h12345678,
        32'h0, 0, "u1_wr40");
    txn(1, 0, 4'hF, 32'h40, 32'h0,
        32'h12345678, 0, "u1_rd40");

    // Request withdrawn before grant
    req[1] = 1'b1;
    we[1] = 1'b1;
    be[1] = 4'hF;
    addr[1] = 32'h40;
    wdata[1] = 32'hFFFF0000;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    we[1] = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt[1] || rvalid[1]) hits++;
      @(posedge clk);
      #1;
    end
    check("drop_no_resp", hits, 32'd0);
    txn(1, 0, 4'hF, 32'h40, 32'h0,
        32'h12345678, 0, "u1_rd40_after_drop");

    // Reset while a response is pending
    txn(2, 1, 4'hF, 32'h8, 32'hCAFEF00D,
        32'h0, 0, "u2_wr8");
    txn(2, 0, 4'hF, 32'h8, 32'h0,
        32'hCAFEF00D, 0, "u2_rd8");
    req[2] = 1'b1;
    we[2] = 1'b0;
    be[2] = 4'hF;
    addr[2] = 32'h8;
    @(negedge clk);
    check("u2_rst_gnt", 32'(gnt[2]), 32'd1);
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("u2_rst_rvalid", 32'(rvalid[2]), 32'd0);
    check("u2_rst_rdata", rdata[2], 32'd0);
    check("u2_rst_err", 32'(err[2]), 32'd0);
    check("u2_rst_gnt0", 32'(gnt[2]), 32'd0);
    hits = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (rvalid[2]) hits++;
    end
    check("u2_rst_no_rv", hits, 32'd0);
    @(posedge clk);
    #1;
    txn(2, 0, 4'hF, 32'h8, 32'h0,
        32'hCAFEF00D, 0, "u2_rd8_after_rst");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
